// File: rtl/bankswitch_select.sv
// Classifies a freshly loaded ROM image into a bank-switching scheme code from its size, detector hits and a superchip heuristic.
// Latency: load_done to type_valid is SETTLE_CYCLES+2 clocks. No backpressure: one byte is accepted per ena, and the mapper waits for type_valid.
module bankswitch_select #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SC_BYTES      = 128
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_start_i,
    input  logic        ena_i,
    input  logic [14:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        load_done_i,
    input  logic        match_e0_i,
    input  logic        match_fe_i,
    output logic [3:0]  bs_type_o,
    output logic        sc_o,
    output logic [15:0] rom_size_o,
    output logic        type_valid_o,
    output logic        busy_o
);

    localparam logic [3:0]  SETTLE_W   = 4'(SETTLE_CYCLES);
    localparam logic [15:0] SC_BYTES_W = 16'(SC_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [3:0]  settle_q;
    logic [7:0]  ref_q;
    logic        sc_ok_q;
    logic        f_e0_q;
    logic        f_fe_q;
    logic [3:0]  bs_type_q;
    logic        sc_q;
    logic [15:0] rom_size_q;
    logic        type_valid_q;
    logic        busy_q;

    logic        sc_eff;
    logic [3:0]  bs_type_d;
    logic        sc_d;
    logic        in_sc_window;

    assign sc_eff       = sc_ok_q && (count_q >= SC_BYTES_W);
    assign in_sc_window = ({1'b0, addr_i} < SC_BYTES_W);

    always_comb begin
        bs_type_d = 4'd15;
        if (count_q >= 16'd1 && count_q <= 16'd2048) begin
            bs_type_d = 4'd0;
        end else begin
            case (count_q)
                16'd4096:  bs_type_d = 4'd1;
                16'd8192:  bs_type_d = f_e0_q ? 4'd4 : (f_fe_q ? 4'd5 : (sc_eff ? 4'd3 : 4'd2));
                16'd12288: bs_type_d = 4'd6;
                16'd16384: bs_type_d = sc_eff ? 4'd8 : 4'd7;
                16'd32768: bs_type_d = sc_eff ? 4'd10 : 4'd9;
                default:   bs_type_d = 4'd15;
            endcase
        end
        sc_d = (bs_type_d == 4'd3) || (bs_type_d == 4'd8) || (bs_type_d == 4'd10);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            count_q      <= 16'd0;
            settle_q     <= 4'd0;
            ref_q        <= 8'd0;
            sc_ok_q      <= 1'b0;
            f_e0_q       <= 1'b0;
            f_fe_q       <= 1'b0;
            bs_type_q    <= 4'd1;
            sc_q         <= 1'b0;
            rom_size_q   <= 16'd0;
            type_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (load_start_i) begin
            // A new image restarts from any state, including mid-load or mid-settle.
            state_q      <= ST_LOAD;
            count_q      <= 16'd0;
            settle_q     <= 4'd0;
            ref_q        <= 8'd0;
            sc_ok_q      <= 1'b1;
            f_e0_q       <= 1'b0;
            f_fe_q       <= 1'b0;
            type_valid_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ena_i) begin
                        if (count_q != 16'hFFFF) begin
                            count_q <= count_q + 16'd1;
                        end
                        if (in_sc_window) begin
                            if (addr_i == 15'd0) begin
                                ref_q <= data_i;
                            end else if (data_i != ref_q) begin
                                sc_ok_q <= 1'b0;
                            end
                        end
                    end
                    if (match_e0_i) f_e0_q <= 1'b1;
                    if (match_fe_i) f_fe_q <= 1'b1;
                    if (load_done_i) begin
                        state_q  <= ST_SETTLE;
                        settle_q <= SETTLE_W;
                    end
                end
                ST_SETTLE: begin
                    // Detector pipelines may still report a hit after the last byte.
                    if (match_e0_i) f_e0_q <= 1'b1;
                    if (match_fe_i) f_fe_q <= 1'b1;
                    if (settle_q == 4'd0) begin
                        state_q <= ST_DECIDE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                ST_DECIDE: begin
                    bs_type_q    <= bs_type_d;
                    sc_q         <= sc_d;
                    rom_size_q   <= count_q;
                    type_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bs_type_o    = bs_type_q;
    assign sc_o         = sc_q;
    assign rom_size_o   = rom_size_q;
    assign type_valid_o = type_valid_q;
    assign busy_o       = busy_q;

endmodule
